issue_select: RTL and testbench

Parametrised multi-issue select stage for the out-of-order issue queue. It generalises the fixed 16-entry, single-grant tree arbiter. It takes a per-entry ready vector, picks up to ISSUE_WIDTH entries per cycle in fixed or rotating priority, and presents registered grants and encoded indices to the register-read/execute side. STALL and FLUSH from the pipeline control path are obeyed.

---
 rtl/issue_select.sv | 90 +++++++++
 tb/tb_issue_select.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/issue_select.sv
// Multi-issue select stage: picks up to ISSUE_WIDTH ready entries per cycle
// in fixed or rotating priority and registers the grants and slot indices.
module issue_select #(
  parameter  int ENTRIES     = 16,
  parameter  int ISSUE_WIDTH = 2,
  parameter  int RR_MODE     = 1,
  localparam int IDX_W       = $clog2(ENTRIES)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         stall_i,
  input  logic                         flush_i,
  input  logic [ENTRIES-1:0]           req_i,
  output logic [ENTRIES-1:0]           grant_o,
  output logic [ISSUE_WIDTH-1:0]       issue_valid_o,
  output logic [ISSUE_WIDTH*IDX_W-1:0] issue_idx_o,
  output logic [IDX_W-1:0]             ptr_o
);

  localparam logic [2:0] IW = 3'(ISSUE_WIDTH);

  logic [ENTRIES-1:0]           grant_q, grant_d;
  logic [ISSUE_WIDTH-1:0]       valid_q, valid_d;
  logic [ISSUE_WIDTH*IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0]             ptr_q, ptr_d;

  logic [ENTRIES-1:0] elig_s;
  logic [IDX_W-1:0]   start_s;
  logic [IDX_W-1:0]   cand_s;
  logic [IDX_W-1:0]   last_s;
  logic [2:0]         cnt_s;

  // Flat circular scan from the start index; slot k takes the (k+1)-th eligible entry.
  always_comb begin
    elig_s  = req_i & ~grant_q;
    start_s = (RR_MODE != 0) ? ptr_q : '0;
    grant_d = '0;
    valid_d = '0;
    idx_d   = '0;
    last_s  = ptr_q;
    cnt_s   = 3'd0;
    cand_s  = '0;
    for (int j = 0; j < ENTRIES; j++) begin
      cand_s = start_s + IDX_W'(j);
      if (elig_s[cand_s] && (cnt_s < IW)) begin
        grant_d[cand_s] = 1'b1;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
          valid_d[k]                 = valid_d[k] | (cnt_s == 3'(k));
          idx_d[k*IDX_W +: IDX_W]    = (cnt_s == 3'(k)) ? cand_s : idx_d[k*IDX_W +: IDX_W];
        end
        last_s = cand_s + {{(IDX_W-1){1'b0}}, 1'b1};
        cnt_s  = cnt_s + 3'd1;
      end else begin
        cnt_s = cnt_s;
      end
    end
    // PTR only advances in rotating mode and only when something issued.
    if ((RR_MODE != 0) && valid_d[0]) begin
      ptr_d = last_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Output/pointer registers; flush overrides stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q <= '0;
      valid_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else if (flush_i) begin
      grant_q <= '0;
      valid_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else if (!stall_i) begin
      grant_q <= grant_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant_o       = grant_q;
  assign issue_valid_o = valid_q;
  assign issue_idx_o   = idx_q;
  assign ptr_o         = ptr_q;

endmodule

// File: tb/tb_issue_select.sv
// Directed, table-driven bench for issue_select: a rotating 16x2 instance and
// a fixed-priority 16x4 instance.
module tb_issue_select;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [15:0] req;
  logic [15:0] req_fix;

  logic [15:0] grant;
  logic [1:0]  valid;
  logic [7:0]  idx;
  logic [3:0]  ptr;

  logic [15:0] grant_fix;
  logic [3:0]  valid_fix;
  logic [15:0] idx_fix;
  logic [3:0]  ptr_fix;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [15:0] req;
    logic [15:0] grant;
    logic [1:0]  valid;
    logic [7:0]  idx;
    logic [3:0]  ptr;
  } vec_t;

  vec_t vecs[16];

  issue_select #(.ENTRIES(16), .ISSUE_WIDTH(2), .RR_MODE(1)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .flush_i(flush),
    .req_i(req), .grant_o(grant), .issue_valid_o(valid),
    .issue_idx_o(idx), .ptr_o(ptr)
  );

  issue_select #(.ENTRIES(16), .ISSUE_WIDTH(4), .RR_MODE(0)) u_fix (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .flush_i(flush),
    .req_i(req_fix), .grant_o(grant_fix), .issue_valid_o(valid_fix),
    .issue_idx_o(idx_fix), .ptr_o(ptr_fix)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rr(input string tag, input logic [15:0] g, input logic [1:0] v,
                          input logic [7:0] ix, input logic [3:0] p);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".valid"}, 32'(valid), 32'(v));
    check({tag, ".idx"},   32'(idx),   32'(ix));
    check({tag, ".ptr"},   32'(ptr),   32'(p));
  endtask

  initial begin
    // stall, flush, req, grant, valid, idx {slot1,slot0}, ptr
    vecs[0]  = '{1'b0, 1'b0, 16'h8011, 16'h0011, 2'b11, 8'h40, 4'd5};
    vecs[1]  = '{1'b0, 1'b0, 16'h8011, 16'h8000, 2'b01, 8'h0F, 4'd0};
    vecs[2]  = '{1'b0, 1'b0, 16'h2000, 16'h2000, 2'b01, 8'h0D, 4'd14};
    vecs[3]  = '{1'b0, 1'b0, 16'h4003, 16'h4001, 2'b11, 8'h0E, 4'd1};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 8'h00, 4'd1};
    vecs[5]  = '{1'b0, 1'b0, 16'h0030, 16'h0030, 2'b11, 8'h54, 4'd6};
    vecs[6]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0030, 2'b11, 8'h54, 4'd6};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 16'h0030, 2'b11, 8'h54, 4'd6};
    vecs[8]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0030, 2'b11, 8'h54, 4'd6};
    vecs[9]  = '{1'b0, 1'b0, 16'h0030, 16'h0000, 2'b00, 8'h00, 4'd6};
    vecs[10] = '{1'b0, 1'b0, 16'hFFFF, 16'h00C0, 2'b11, 8'h76, 4'd8};
    vecs[11] = '{1'b0, 1'b0, 16'hFFFF, 16'h0300, 2'b11, 8'h98, 4'd10};
    vecs[12] = '{1'b1, 1'b1, 16'hFFFF, 16'h0000, 2'b00, 8'h00, 4'd0};
    vecs[13] = '{1'b0, 1'b0, 16'h0001, 16'h0001, 2'b01, 8'h00, 4'd1};
    vecs[14] = '{1'b0, 1'b0, 16'h0001, 16'h0000, 2'b00, 8'h00, 4'd1};
    vecs[15] = '{1'b0, 1'b0, 16'h0011, 16'h0011, 2'b11, 8'h04, 4'd1};

    rst_n   = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    req     = 16'h0000;
    req_fix = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check_rr("reset", 16'h0000, 2'b00, 8'h00, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      stall = vecs[i].stall;
      flush = vecs[i].flush;
      req   = vecs[i].req;
      @(posedge clk);
      #1;
      check_rr($sformatf("vec%0d", i), vecs[i].grant, vecs[i].valid, vecs[i].idx, vecs[i].ptr);
    end

    // Asynchronous reset mid-operation with GRANT=0x0011 and PTR=1.
    @(negedge clk);
    req = 16'h0000;
    #2;
    rst_n = 1'b0;
    #1;
    check_rr("async_rst", 16'h0000, 2'b00, 8'h00, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 16'h0011;
    @(posedge clk);
    #1;
    check_rr("post_rst", 16'h0011, 2'b11, 8'h40, 4'd5);

    // Fixed-priority, four-wide: lowest indices first, PTR pinned at 0.
    @(negedge clk);
    req     = 16'h0000;
    req_fix = 16'h00F2;
    @(posedge clk);
    #1;
    check("fix1.grant", 32'(grant_fix), 32'h0072);
    check("fix1.valid", 32'(valid_fix), 32'hF);
    check("fix1.idx",   32'(idx_fix),   32'h6541);
    check("fix1.ptr",   32'(ptr_fix),   32'h0);
    @(posedge clk);
    #1;
    check("fix2.grant", 32'(grant_fix), 32'h0080);
    check("fix2.valid", 32'(valid_fix), 32'h1);
    check("fix2.idx",   32'(idx_fix),   32'h0007);
    check("fix2.ptr",   32'(ptr_fix),   32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
